// File: rtl/perceptron_predictor.sv
// Perceptron conditional-branch direction predictor.
// The lookup port (fetch) produces a prediction two cycles after a request,
// one request per cycle. The update port (execute) trains one table entry per
// accepted update through a three-cycle read-modify-write sequence. The
// speculative global history is repaired from the returned checkpoint on a
// mispredict. After reset the whole table is swept to zero.
module perceptron_predictor #(
    parameter int HIST_LEN = 16,
    parameter int WEIGHT_W = 8,
    parameter int IDX_W    = 6,
    parameter int THETA    = 44,
    localparam int SUM_W   = WEIGHT_W + $clog2(HIST_LEN + 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    // lookup port
    input  logic                    lu_valid,
    input  logic [31:0]             lu_pc,
    output logic                    pred_valid,
    output logic                    pred_dir,
    output logic signed [SUM_W-1:0] pred_sum,
    output logic [HIST_LEN-1:0]     pred_ghr,
    // update port
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [31:0]             upd_pc,
    input  logic [HIST_LEN-1:0]     upd_ghr,
    input  logic signed [SUM_W-1:0] upd_sum,
    input  logic                    upd_dir,
    input  logic                    upd_mispredict,
    // status
    output logic                    init_busy
);

    localparam int ENTRY_W = (HIST_LEN + 1) * WEIGHT_W;
    localparam int DEPTH   = 2 ** IDX_W;

    // Weights saturate symmetrically; the most-negative code is never produced.
    localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-2){1'b0}}, 1'b1};
    localparam logic signed [SUM_W:0] THETA_S = (SUM_W+1)'(THETA);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

    // Entry layout: bias weight in slice 0, weight i (paired with ghr[i-1]) in slice i.
    logic [ENTRY_W-1:0] table_mem [DEPTH];

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr;
    logic [HIST_LEN-1:0] ghr_q;

    // lookup pipeline
    logic                    s1_valid;
    logic [ENTRY_W-1:0]      s1_rdata;
    logic [HIST_LEN-1:0]     s1_ghr;
    logic signed [SUM_W-1:0] lu_sum;
    logic [IDX_W-1:0]        lu_idx;

    // training path
    logic                    upd_accept;
    logic [IDX_W-1:0]        upd_idx_q;
    logic [HIST_LEN-1:0]     upd_ghr_q;
    logic signed [SUM_W-1:0] upd_sum_q;
    logic                    upd_dir_q;
    logic                    upd_misp_q;
    logic [ENTRY_W-1:0]      tr_rdata;
    logic                    train_q;
    logic signed [SUM_W:0]   upd_sum_ext;
    logic signed [SUM_W:0]   upd_sum_abs;
    logic [ENTRY_W-1:0]      new_entry;

    // table write port
    logic                    tbl_we;
    logic [IDX_W-1:0]        tbl_waddr;
    logic [ENTRY_W-1:0]      tbl_wdata;

    // Only the word-index bits of the PCs select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lu_pc[31:IDX_W+2], lu_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign lu_idx     = lu_pc[IDX_W+1:2];
    assign upd_accept = upd_valid & upd_ready;

    function automatic logic signed [SUM_W-1:0] sext(input logic [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic up);
        if (up)
            return (w == W_MAX) ? w : w + WEIGHT_W'(1);
        else
            return (w == W_MIN) ? w : w - WEIGHT_W'(1);
    endfunction

    // Training FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Training FSM next state, handshake outputs and table write request.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        upd_ready = 1'b0;
        init_busy = 1'b0;
        tbl_we    = 1'b0;
        tbl_waddr = init_ptr;
        tbl_wdata = '0;
        case (state_q)
            S_INIT: begin
                init_busy = 1'b1;
                tbl_we    = 1'b1;
                if (init_ptr == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) state_d = S_RD;
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                tbl_we    = train_q;
                tbl_waddr = upd_idx_q;
                tbl_wdata = new_entry;
                state_d   = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Clear-sweep pointer, advancing one entry per INIT cycle.
    always_ff @(posedge clk) begin
        if (reset)                  init_ptr <= '0;
        else if (state_q == S_INIT) init_ptr <= init_ptr + IDX_W'(1);
    end

    // Table write port; a write in the reset cycle is suppressed so an interrupted RMW is dropped.
    always_ff @(posedge clk) begin
        // NOTE: the table itself is not reset; the INIT sweep clears it instead,
        // which keeps it mappable onto block RAM.
        if (tbl_we && !reset) table_mem[tbl_waddr] <= tbl_wdata;
    end

    // Speculative history: mispredict recovery wins over the shift of a same-cycle prediction.
    always_ff @(posedge clk) begin
        if (reset)
            ghr_q <= '0;
        else if (upd_accept && upd_mispredict)
            ghr_q <= {upd_ghr[HIST_LEN-2:0], upd_dir};
        else if (pred_valid)
            ghr_q <= {ghr_q[HIST_LEN-2:0], pred_dir};
    end

    // Lookup stage 0 -> 1 valid; requests during the clear sweep are dropped.
    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= lu_valid && (state_q != S_INIT);
    end

    // Datapath registers: lookup read data, latched update fields, training read.
    always_ff @(posedge clk) begin
        s1_rdata <= table_mem[lu_idx];
        s1_ghr   <= ghr_q;
        if (upd_accept) begin
            upd_idx_q  <= upd_pc[IDX_W+1:2];
            upd_ghr_q  <= upd_ghr;
            upd_sum_q  <= upd_sum;
            upd_dir_q  <= upd_dir;
            upd_misp_q <= upd_mispredict;
        end
        if (state_q == S_RD) begin
            tr_rdata <= table_mem[upd_idx_q];
            train_q  <= upd_misp_q || (upd_sum_abs <= THETA_S);
        end
    end

    // Magnitude of the returned sum, one bit wider so the most-negative sum stays positive.
    assign upd_sum_ext = {upd_sum_q[SUM_W-1], upd_sum_q};
    assign upd_sum_abs = upd_sum_ext[SUM_W] ? -upd_sum_ext : upd_sum_ext;

    // Perceptron dot product over the registered entry and captured history.
    always_comb begin
        lu_sum = sext(s1_rdata[WEIGHT_W-1:0]);
        for (int i = 1; i <= HIST_LEN; i++) begin
            if (s1_ghr[i-1]) lu_sum = lu_sum + sext(s1_rdata[i*WEIGHT_W +: WEIGHT_W]);
            else             lu_sum = lu_sum - sext(s1_rdata[i*WEIGHT_W +: WEIGHT_W]);
        end
    end

    // Trained entry: each weight steps one toward agreement with the outcome.
    always_comb begin
        new_entry = tr_rdata;
        new_entry[WEIGHT_W-1:0] = sat_step(tr_rdata[WEIGHT_W-1:0], upd_dir_q);
        for (int i = 1; i <= HIST_LEN; i++) begin
            new_entry[i*WEIGHT_W +: WEIGHT_W] =
                sat_step(tr_rdata[i*WEIGHT_W +: WEIGHT_W], upd_dir_q == upd_ghr_q[i-1]);
        end
    end

    // Prediction output register (lookup stage 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_dir   <= 1'b0;
            pred_sum   <= '0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= s1_valid && (state_q != S_INIT);
            if (s1_valid) begin
                pred_dir <= ~lu_sum[SUM_W-1];
                pred_sum <= lu_sum;
                pred_ghr <= s1_ghr;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed testbench for perceptron_predictor: reset and clear sweep,
// threshold training, saturation, pipelined lookups, mispredict recovery
// and reset during a training write.
module tb_perceptron_predictor;

    localparam int HIST_LEN = 16;
    localparam int SUM_W    = 13;
    localparam logic [31:0] SCRATCH_PC = 32'h0000_00FC;

    logic                    clk;
    logic                    reset;
    logic                    lu_valid;
    logic [31:0]             lu_pc;
    logic                    pred_valid;
    logic                    pred_dir;
    logic signed [SUM_W-1:0] pred_sum;
    logic [HIST_LEN-1:0]     pred_ghr;
    logic                    upd_valid;
    logic                    upd_ready;
    logic [31:0]             upd_pc;
    logic [HIST_LEN-1:0]     upd_ghr;
    logic signed [SUM_W-1:0] upd_sum;
    logic                    upd_dir;
    logic                    upd_mispredict;
    logic                    init_busy;

    int errors = 0;
    int checks = 0;

    perceptron_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .lu_valid       (lu_valid),
        .lu_pc          (lu_pc),
        .pred_valid     (pred_valid),
        .pred_dir       (pred_dir),
        .pred_sum       (pred_sum),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_sum        (upd_sum),
        .upd_dir        (upd_dir),
        .upd_mispredict (upd_mispredict),
        .init_busy      (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Count negedges with init_busy high, starting at the negedge where reset was released.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // One lookup; the prediction is sampled exactly two cycles after the request edge.
    task automatic lookup(input logic [31:0] pc, output logic v, output logic signed [SUM_W-1:0] s,
                          output logic d, output logic [HIST_LEN-1:0] g);
        @(negedge clk);
        lu_valid = 1'b1;
        lu_pc    = pc;
        @(negedge clk);
        lu_valid = 1'b0;
        @(negedge clk);
        v = pred_valid;
        s = pred_sum;
        d = pred_dir;
        g = pred_ghr;
    endtask

    // One update; returns once the RMW has completed and the port is ready again.
    task automatic do_update(input logic [31:0] pc, input logic [HIST_LEN-1:0] g,
                             input logic signed [SUM_W-1:0] s, input logic d, input logic m);
        int n;
        n = 0;
        @(negedge clk);
        while (upd_ready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        if (upd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL upd_ready_before: got %b expected 1 within 20 cycles", upd_ready);
        end
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = g;
        upd_sum        = s;
        upd_dir        = d;
        upd_mispredict = m;
        @(negedge clk);
        upd_valid = 1'b0;
        n = 0;
        while (upd_ready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        if (upd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL upd_ready_after: got %b expected 1 within 20 cycles", upd_ready);
        end
    endtask

    // Force the history to a value through a mispredict on the scratch entry.
    task automatic set_ghr(input logic [HIST_LEN-1:0] v);
        do_update(SCRATCH_PC, {1'b0, v[HIST_LEN-1:1]}, '0, v[0], 1'b1);
    endtask

    task automatic test_reset();
        int  cycles;
        logic saw_pred;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL rst_pred_valid: got %b expected 0", pred_valid); end
        checks++; if (pred_dir !== 1'b0)   begin errors++; $display("FAIL rst_pred_dir: got %b expected 0", pred_dir); end
        checks++; if (pred_sum !== '0)     begin errors++; $display("FAIL rst_pred_sum: got %0d expected 0", pred_sum); end
        checks++; if (pred_ghr !== '0)     begin errors++; $display("FAIL rst_pred_ghr: got %h expected 0", pred_ghr); end
        checks++; if (upd_ready !== 1'b0)  begin errors++; $display("FAIL rst_upd_ready: got %b expected 0", upd_ready); end
        checks++; if (init_busy !== 1'b1)  begin errors++; $display("FAIL rst_init_busy: got %b expected 1", init_busy); end
        // Lookups requested throughout the sweep must be ignored.
        reset    = 1'b0;
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_0040;
        cycles   = 0;
        saw_pred = 1'b0;
        while (init_busy === 1'b1 && cycles < 200) begin
            cycles++;
            saw_pred = saw_pred | pred_valid;
            @(negedge clk);
        end
        lu_valid = 1'b0;
        repeat (3) begin
            saw_pred = saw_pred | pred_valid;
            @(negedge clk);
        end
        checks++; if (cycles != 64)       begin errors++; $display("FAIL init_cycles: got %0d expected 64", cycles); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready: got %b expected 1", upd_ready); end
        checks++; if (saw_pred !== 1'b0)  begin errors++; $display("FAIL init_lookup_ignored: got pred_valid %b expected 0", saw_pred); end
    endtask

    task automatic test_init_lookup();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        lookup(32'h0000_1234, v, s, d, g);
        checks++; if (v !== 1'b1)  begin errors++; $display("FAIL init_lu_valid: got %b expected 1", v); end
        checks++; if (s !== '0)    begin errors++; $display("FAIL init_lu_sum: got %0d expected 0", s); end
        checks++; if (d !== 1'b1)  begin errors++; $display("FAIL init_lu_dir: got %b expected 1", d); end
        checks++; if (g !== '0)    begin errors++; $display("FAIL init_lu_ghr: got %h expected 0", g); end
    endtask

    // Taken training with ghr=0: each train adds +1 to bias and -1 to every w_i,
    // so the sum at ghr=0 grows by 17 per train and stops at 51 (> 44).
    task automatic test_threshold();
        logic v, d;
        logic signed [SUM_W-1:0] s, exp_s;
        logic [HIST_LEN-1:0] g;
        int exp_sum[8] = '{0, 17, 34, 51, 51, 51, 51, 51};
        for (int n = 0; n < 8; n++) begin
            set_ghr(16'h0000);
            lookup(32'h0000_0100, v, s, d, g);
            exp_s = SUM_W'(exp_sum[n]);
            checks++; if (s !== exp_s) begin errors++; $display("FAIL thresh_sum[%0d]: got %0d expected %0d", n, s, exp_s); end
            checks++; if (g !== '0)    begin errors++; $display("FAIL thresh_ghr[%0d]: got %h expected 0", n, g); end
            do_update(32'h0000_0100, 16'h0000, exp_s, 1'b1, 1'b0);
        end
    endtask

    // Training decision at the edges of the threshold and at the most-negative sum.
    task automatic test_theta_boundary();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        int   sum_v[6]  = '{45, 44, -45, -44, -4096, 100};
        logic misp_v[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   exp_v[6]  = '{0, 17, 17, 34, 34, 51};
        for (int i = 0; i < 6; i++) begin
            do_update(32'h0000_0104, 16'h0000, SUM_W'(sum_v[i]), 1'b1, misp_v[i]);
            set_ghr(16'h0000);
            lookup(32'h0000_0104, v, s, d, g);
            checks++;
            if (s !== SUM_W'(exp_v[i])) begin
                errors++;
                $display("FAIL theta_sum[upd_sum=%0d]: got %0d expected %0d", sum_v[i], s, exp_v[i]);
            end
        end
    endtask

    // Weights pinned at +127 / -127 after more trains than the range allows.
    task automatic test_saturation();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        repeat (130) do_update(32'h0000_0108, 16'hFFFF, '0, 1'b1, 1'b1);
        lookup(32'h0000_0108, v, s, d, g);
        checks++; if (s !== 13'sd2159)  begin errors++; $display("FAIL sat_pos_sum: got %0d expected 2159", s); end
        checks++; if (d !== 1'b1)       begin errors++; $display("FAIL sat_pos_dir: got %b expected 1", d); end
        checks++; if (g !== 16'hFFFF)   begin errors++; $display("FAIL sat_pos_ghr: got %h expected ffff", g); end
        repeat (130) do_update(32'h0000_010C, 16'hFFFF, '0, 1'b0, 1'b1);
        // ghr = 0xFFFE: -127 (bias) + 127 (w1, bit clear) - 15*127 = -1905
        lookup(32'h0000_010C, v, s, d, g);
        checks++; if (s !== -13'sd1905) begin errors++; $display("FAIL sat_neg_sum: got %0d expected -1905", s); end
        checks++; if (d !== 1'b0)       begin errors++; $display("FAIL sat_neg_dir: got %b expected 0", d); end
        checks++; if (g !== 16'hFFFE)   begin errors++; $display("FAIL sat_neg_ghr: got %h expected fffe", g); end
    endtask

    task automatic test_back_to_back();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        logic pv[5];
        logic pd[5];
        logic [HIST_LEN-1:0] pg[5];
        logic exp_pv[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        set_ghr(16'h0000);
        @(negedge clk);
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_0028;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pv[k] = pred_valid;
            pd[k] = pred_dir;
            pg[k] = pred_ghr;
            if (k == 2) lu_valid = 1'b0;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pv[k] !== exp_pv[k]) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, pv[k], exp_pv[k]); end
            if (exp_pv[k]) begin
                checks++; if (pg[k] !== '0)   begin errors++; $display("FAIL b2b_ghr[%0d]: got %h expected 0", k, pg[k]); end
                checks++; if (pd[k] !== 1'b1) begin errors++; $display("FAIL b2b_dir[%0d]: got %b expected 1", k, pd[k]); end
            end
        end
        lookup(32'h0000_0028, v, s, d, g);
        checks++; if (g !== 16'h0007) begin errors++; $display("FAIL b2b_ghr_after: got %h expected 0007", g); end
    endtask

    task automatic test_mispredict_recovery();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        int n;
        set_ghr(16'h0000);
        @(negedge clk);
        lu_valid = 1'b1;
        lu_pc    = 32'h0000_002C;
        @(negedge clk);
        lu_valid = 1'b0;
        @(negedge clk);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL recov_pred_valid: got %b expected 1", pred_valid); end
        checks++; if (upd_ready !== 1'b1)  begin errors++; $display("FAIL recov_upd_ready: got %b expected 1", upd_ready); end
        upd_valid      = 1'b1;
        upd_pc         = SCRATCH_PC;
        upd_ghr        = 16'h00A5;
        upd_sum        = '0;
        upd_dir        = 1'b0;
        upd_mispredict = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        n = 0;
        while (upd_ready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL recov_ready_timeout: got %b expected 1", upd_ready); end
        lookup(32'h0000_002C, v, s, d, g);
        checks++; if (g !== 16'h014A) begin errors++; $display("FAIL recov_ghr: got %h expected 014a", g); end
    endtask

    task automatic test_reset_during_wr();
        logic v, d;
        logic signed [SUM_W-1:0] s;
        logic [HIST_LEN-1:0] g;
        int cycles;
        logic [31:0] pcs[6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h114, 32'hFC};
        @(negedge clk);
        upd_valid      = 1'b1;
        upd_pc         = 32'h0000_0114;
        upd_ghr        = 16'hFFFF;
        upd_sum        = '0;
        upd_dir        = 1'b1;
        upd_mispredict = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL wr_upd_ready: got %b expected 0", upd_ready); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (init_busy !== 1'b1)  begin errors++; $display("FAIL wr_rst_busy: got %b expected 1", init_busy); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL wr_rst_pred_valid: got %b expected 0", pred_valid); end
        wait_init(cycles);
        checks++; if (cycles != 64) begin errors++; $display("FAIL wr_init_cycles: got %0d expected 64", cycles); end
        for (int i = 0; i < 6; i++) begin
            lookup(pcs[i], v, s, d, g);
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL wr_clear_valid[%h]: got %b expected 1", pcs[i], v); end
            checks++; if (s !== '0)   begin errors++; $display("FAIL wr_clear_sum[%h]: got %0d expected 0", pcs[i], s); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        lu_valid       = 1'b0;
        lu_pc          = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_ghr        = '0;
        upd_sum        = '0;
        upd_dir        = 1'b0;
        upd_mispredict = 1'b0;
        test_reset();
        test_init_lookup();
        test_threshold();
        test_theta_boundary();
        test_saturation();
        test_back_to_back();
        test_mispredict_recovery();
        test_reset_during_wr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
